reg_write_arbiter: RTL and testbench

//  Shares the single register-file write port among 4 requesters (REQ[3:0]).

---
 rtl/reg_write_arbiter_pkg.sv | 16 +
 rtl/reg_write_arbiter_rr_pick.sv | 27 ++
 rtl/reg_write_arbiter.sv | 118 +++++++++++
 tb/tb_reg_write_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Imported by the arbiter top and its round-robin picker.
package reg_write_arbiter_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Rotated 4-input priority encoder: first set REQ bit scanning
// PTR, PTR+1, ... (mod 4).
module rr_pick
    import reg_write_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] REQ,
    input  logic [1:0]       PTR,
    output logic             VALID,
    output logic [1:0]       IDX
);

    logic [1:0] cand;

    // Scan from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        VALID = |REQ;
        IDX   = PTR;
        cand  = PTR;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = PTR + 2'(k);
            if (REQ[cand]) begin
                IDX = cand;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the single regfile write port among
// four requesters, with capped burst length and registered write outputs.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int HOLD_MAX = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [N_REQ-1:0]        REQ,
    input  logic [N_REQ-1:0]        LAST,
    input  logic [N_REQ*DATA_W-1:0] WDATA,
    input  logic [N_REQ*ADDR_W-1:0] WADDR,
    output logic [N_REQ-1:0]        GNT,
    output logic [1:0]              SEL,
    output logic                    BUSY,
    output logic                    REG_WE,
    output logic [ADDR_W-1:0]       REG_WADDR,
    output logic [DATA_W-1:0]       REG_WDATA
);

    state_e             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [3:0]         beat_q, beat_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [1:0]         sel_q, sel_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    logic               pick_valid;
    logic [1:0]         pick_idx;
    logic               accept;
    logic [3:0]         beat_inc;

    rr_pick u_pick (
        .REQ   (REQ),
        .PTR   (ptr_q),
        .VALID (pick_valid),
        .IDX   (pick_idx)
    );

    assign accept   = REQ[sel_q];
    assign beat_inc = beat_q + 4'd1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    gnt_d   = onehot4(pick_idx);
                    sel_d   = pick_idx;
                    beat_d  = 4'd0;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = WADDR[sel_q*ADDR_W +: ADDR_W];
                    wdata_d = WDATA[sel_q*DATA_W +: DATA_W];
                    beat_d  = beat_inc;
                end
                // Release on drop, LAST, or the burst cap; the final beat still writes.
                if (!accept || LAST[sel_q] || beat_inc == 4'(HOLD_MAX)) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    sel_d   = 2'd0;
                    ptr_d   = sel_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                sel_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            beat_q  <= 4'd0;
            gnt_q   <= '0;
            sel_q   <= 2'd0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign GNT       = gnt_q;
    assign SEL       = sel_q;
    assign BUSY      = (state_q == ST_GRANT);
    assign REG_WE    = we_q;
    assign REG_WADDR = waddr_q;
    assign REG_WDATA = wdata_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a cycle model predicts grants
// and queues expected writes, which are popped as REG_WE pulses appear.
module tb_reg_write_arbiter;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 2;
    localparam int HOLD_MAX = 4;

    logic        CLK;
    logic        RST_N;
    logic [3:0]  REQ;
    logic [3:0]  LAST;
    logic [31:0] WDATA;
    logic [7:0]  WADDR;
    logic [3:0]  GNT;
    logic [1:0]  SEL;
    logic        BUSY;
    logic        REG_WE;
    logic [1:0]  REG_WADDR;
    logic [7:0]  REG_WDATA;

    int checks   = 0;
    int failures = 0;

    logic       m_busy;
    int         m_idx;
    int         m_ptr;
    int         m_beat;
    logic       m_we;
    logic [9:0] sb[$];

    int         order[$];
    int         we_cnt;
    int         wa_q[$];
    logic [3:0] prev_gnt;

    reg_write_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ       (REQ),
        .LAST      (LAST),
        .WDATA     (WDATA),
        .WADDR     (WADDR),
        .GNT       (GNT),
        .SEL       (SEL),
        .BUSY      (BUSY),
        .REG_WE    (REG_WE),
        .REG_WADDR (REG_WADDR),
        .REG_WDATA (REG_WDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_busy = 1'b0;
        m_idx  = 0;
        m_ptr  = 0;
        m_beat = 0;
        m_we   = 1'b0;
        sb.delete();
    endfunction

    function automatic void model_edge();
        bit rel;
        bit found;
        if (!RST_N) begin
            model_reset();
            return;
        end
        m_we = 1'b0;
        rel  = 1'b0;
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (!found && REQ[j]) begin
                    found  = 1'b1;
                    m_busy = 1'b1;
                    m_idx  = j;
                    m_beat = 0;
                end
            end
        end else begin
            if (REQ[m_idx]) begin
                m_we = 1'b1;
                sb.push_back({WADDR[m_idx*2 +: 2], WDATA[m_idx*8 +: 8]});
                m_beat++;
                if (LAST[m_idx] || m_beat == HOLD_MAX) rel = 1'b1;
            end else begin
                rel = 1'b1;
            end
            if (rel) begin
                m_busy = 1'b0;
                m_ptr  = (m_idx + 1) % 4;
            end
        end
    endfunction

    task automatic compare();
        logic [9:0] e;
        check("gnt", {28'd0, GNT}, m_busy ? (32'd1 << m_idx) : 32'd0);
        check("sel", {30'd0, SEL}, m_busy ? 32'(m_idx) : 32'd0);
        check("busy", {31'd0, BUSY}, {31'd0, m_busy});
        check("we", {31'd0, REG_WE}, {31'd0, m_we});
        if (REG_WE) begin
            we_cnt++;
            wa_q.push_back(int'(REG_WADDR));
            if (sb.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", {30'd0, REG_WADDR}, {30'd0, e[9:8]});
                check("wr_data", {24'd0, REG_WDATA}, {24'd0, e[7:0]});
            end
        end
        if (GNT != 4'd0 && prev_gnt == 4'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (GNT[i]) order.push_back(i);
            end
        end
        prev_gnt = GNT;
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        compare();
        WDATA = $urandom;
    endtask

    task automatic clear_mon();
        order.delete();
        wa_q.delete();
        we_cnt = 0;
    endtask

    task automatic do_reset();
        REQ   = 4'd0;
        LAST  = 4'd0;
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        clear_mon();
    endtask

    function automatic logic [7:0] addr_for(input int i, input logic [1:0] a);
        logic [7:0] v;
        v = 8'd0;
        v[i*2 +: 2] = a;
        return v;
    endfunction

    initial begin
        RST_N    = 1'b0;
        REQ      = 4'hF;
        LAST     = 4'd0;
        WDATA    = 32'hA5A5_5A5A;
        WADDR    = 8'hE4;
        prev_gnt = 4'd0;
        model_reset();
        clear_mon();

        // Reset held with all requests asserted
        #2;
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_gnt", {28'd0, GNT}, 32'd0);
            check("rst_busy", {31'd0, BUSY}, 32'd0);
            check("rst_we", {31'd0, REG_WE}, 32'd0);
            check("rst_waddr", {30'd0, REG_WADDR}, 32'd0);
            check("rst_wdata", {24'd0, REG_WDATA}, 32'd0);
        end
        RST_N = 1'b1;
        REQ   = 4'd0;
        step();

        // Single 3-beat burst from requester 2
        clear_mon();
        REQ   = 4'b0100;
        WADDR = addr_for(2, 2'd1);
        step();
        check("t2_gnt", {28'd0, GNT}, 32'h4);
        step();
        WADDR = addr_for(2, 2'd2);
        step();
        WADDR = addr_for(2, 2'd3);
        LAST  = 4'b0100;
        step();
        check("t2_rel", {28'd0, GNT}, 32'd0);
        REQ  = 4'd0;
        LAST = 4'd0;
        step();
        check("t2_writes", 32'(we_cnt), 32'd3);
        if (wa_q.size() == 3) begin
            check("t2_a0", 32'(wa_q[0]), 32'd1);
            check("t2_a1", 32'(wa_q[1]), 32'd2);
            check("t2_a2", 32'(wa_q[2]), 32'd3);
        end else begin
            check("t2_wa_len", 32'(wa_q.size()), 32'd3);
        end
        REQ = 4'b1001;
        step();
        check("t2_ptr3", {28'd0, GNT}, 32'h8);
        REQ = 4'd0;
        step();
        step();

        // Round-robin, single-beat grants
        do_reset();
        REQ  = 4'hF;
        LAST = 4'hF;
        for (int c = 0; c < 10; c++) step();
        check("t3_len", 32'(order.size()), 32'd5);
        if (order.size() >= 5) begin
            check("t3_o0", 32'(order[0]), 32'd0);
            check("t3_o1", 32'(order[1]), 32'd1);
            check("t3_o2", 32'(order[2]), 32'd2);
            check("t3_o3", 32'(order[3]), 32'd3);
            check("t3_o4", 32'(order[4]), 32'd0);
        end
        REQ  = 4'd0;
        LAST = 4'd0;
        step();
        step();

        // Burst cap on requester 1, then round-robin continues
        do_reset();
        REQ = 4'b0010;
        step();
        REQ  = 4'hF;
        LAST = 4'b1101;
        for (int c = 0; c < 5; c++) step();
        check("t4_cap_we", 32'(we_cnt), 32'd4);
        for (int c = 0; c < 8; c++) step();
        check("t4_len", 32'(order.size()), 32'd5);
        if (order.size() >= 5) begin
            check("t4_o0", 32'(order[0]), 32'd1);
            check("t4_o1", 32'(order[1]), 32'd2);
            check("t4_o2", 32'(order[2]), 32'd3);
            check("t4_o3", 32'(order[3]), 32'd0);
            check("t4_o4", 32'(order[4]), 32'd1);
        end
        REQ  = 4'd0;
        LAST = 4'd0;
        for (int c = 0; c < 3; c++) step();

        // Requester 2 drops after one beat
        do_reset();
        REQ = 4'b0100;
        step();
        step();
        REQ = 4'd0;
        step();
        check("t5_gnt0", {28'd0, GNT}, 32'd0);
        step();
        check("t5_writes", 32'(we_cnt), 32'd1);
        REQ  = 4'hF;
        LAST = 4'hF;
        step();
        check("t5_ptr3", {28'd0, GNT}, 32'h8);
        REQ  = 4'd0;
        LAST = 4'd0;
        step();
        step();

        // Asynchronous reset in the middle of a burst
        do_reset();
        REQ   = 4'b1000;
        WADDR = addr_for(3, 2'd2);
        step();
        step();
        #3;
        RST_N = 1'b0;
        #1;
        model_reset();
        check("t6_gnt", {28'd0, GNT}, 32'd0);
        check("t6_busy", {31'd0, BUSY}, 32'd0);
        check("t6_we", {31'd0, REG_WE}, 32'd0);
        check("t6_waddr", {30'd0, REG_WADDR}, 32'd0);
        check("t6_wdata", {24'd0, REG_WDATA}, 32'd0);
        step();
        RST_N = 1'b1;
        REQ   = 4'b1001;
        step();
        check("t6_ptr0", {28'd0, GNT}, 32'h1);
        REQ = 4'd0;
        step();
        step();

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
